ahb_slave_interface: RTL

AHB-Lite slave front end of the AHB2APB bridge. It sits directly downstream of the AHB master interface and consumes its haddr/hwdata/hwrite/htrans/hready_in. It returns hr_readyout and hr_data to the master. It decodes the peripheral region, captures the address and data phases, and issues one transfer at a time to the APB controller over a valid/done handshake, inserting wait states until that transfer completes.

---
 rtl/ahb_slave_interface.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_slave_interface.sv
// AHB-Lite slave front end of the AHB2APB bridge: decodes the peripheral region,
// captures address/data phases and hands one transfer at a time to the APB controller.
module ahb_slave_interface #(
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hready_in,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hr_readyout,
  output logic [31:0] hr_data,
  output logic [1:0]  hresp,
  output logic        xfer_valid,
  output logic        xfer_write,
  output logic [31:0] xfer_addr,
  output logic [31:0] xfer_wdata,
  output logic [2:0]  xfer_sel,
  input  logic        xfer_done,
  input  logic [31:0] xfer_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR1  = 3'd4,
    ST_ERR2  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] tmo_cnt_r;
  logic        accept_s;
  logic        hit_s;
  logic        tmo_hit_s;
  logic [2:0]  dec_sel_s;

  logic        hr_readyout_r;
  logic [31:0] hr_data_r;
  logic [1:0]  hresp_r;
  logic        xfer_valid_r;
  logic        xfer_write_r;
  logic [31:0] xfer_addr_r;
  logic [31:0] xfer_wdata_r;
  logic [2:0]  xfer_sel_r;

  function automatic logic [2:0] decode_sel(input logic [5:0] region);
    case (region)
      6'b100000: decode_sel = 3'b001;
      6'b100001: decode_sel = 3'b010;
      6'b100010: decode_sel = 3'b100;
      default:   decode_sel = 3'b000;
    endcase
  endfunction

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accept decode and next-state logic
  always_comb begin
    state_nxt_s = state_r;
    dec_sel_s   = decode_sel(haddr[31:26]);
    hit_s       = (dec_sel_s != 3'b000);
    tmo_hit_s   = (TIMEOUT != 32'd0) && (tmo_cnt_r == (TIMEOUT - 32'd1));
    accept_s    = hready_in && hr_readyout_r &&
                  ((htrans == 2'b10) || (htrans == 2'b11)) &&
                  ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR2));
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!hit_s) begin
          state_nxt_s = ST_ERR1;
        end else if (hwrite) begin
          state_nxt_s = ST_WDATA;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WDATA: state_nxt_s = ST_ISSUE;
      ST_ISSUE: begin
        if (xfer_done) begin
          state_nxt_s = ST_DONE;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_ERR1;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered bus outputs, transfer latches and ISSUE timeout counter
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hr_readyout_r <= 1'b1;
      hresp_r       <= 2'b00;
      hr_data_r     <= 32'd0;
      xfer_valid_r  <= 1'b0;
      xfer_write_r  <= 1'b0;
      xfer_addr_r   <= 32'd0;
      xfer_wdata_r  <= 32'd0;
      xfer_sel_r    <= 3'b000;
      tmo_cnt_r     <= 32'd0;
    end else begin
      // Outputs are decoded from the state being entered so they line up with it
      hr_readyout_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE) ||
                       (state_nxt_s == ST_ERR2);
      hresp_r       <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ? 2'b01 : 2'b00;
      xfer_valid_r  <= (state_nxt_s == ST_ISSUE);
      if ((state_r == ST_ISSUE) && (state_nxt_s == ST_ISSUE)) begin
        tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end else begin
        tmo_cnt_r <= 32'd0;
      end
      if (accept_s && hit_s) begin
        xfer_addr_r  <= haddr;
        xfer_write_r <= hwrite;
        xfer_sel_r   <= dec_sel_s;
      end
      if (state_r == ST_WDATA) begin
        xfer_wdata_r <= hwdata;
      end
      if ((state_r == ST_ISSUE) && xfer_done && !xfer_write_r) begin
        hr_data_r <= xfer_rdata;
      end
    end
  end

  assign hr_readyout = hr_readyout_r;
  assign hr_data     = hr_data_r;
  assign hresp       = hresp_r;
  assign xfer_valid  = xfer_valid_r;
  assign xfer_write  = xfer_write_r;
  assign xfer_addr   = xfer_addr_r;
  assign xfer_wdata  = xfer_wdata_r;
  assign xfer_sel    = xfer_sel_r;

endmodule
